// File: rtl/spike_gen_bank_if.sv
// rtl/spike_gen_bank_if.sv - programming and event channels of the spike generator bank
//
// Groups the programming write channel (prog_*) and the tag/count event
// channel (out_*) of spike_gen_bank.
//   master : programmer / event consumer side (drives prog_*, out_r)
//   slave  : generator bank side (drives prog_a, out_tag, out_ct, out_v)
interface spike_gen_bank_if #(
  parameter int Ngens   = 8,
  parameter int Nperiod = 16,
  parameter int Ntag    = 11,
  parameter int Nct     = 10
);
  logic [Ngens-1:0]   prog_gen_idx;
  logic [Nperiod-1:0] prog_period;
  logic [Nperiod-1:0] prog_ticks;
  logic [Ntag-1:0]    prog_tag;
  logic               prog_v;
  logic               prog_a;

  logic [Ntag-1:0]    out_tag;
  logic [Nct-1:0]     out_ct;
  logic               out_v;
  logic               out_r;

  modport master (
    output prog_gen_idx, prog_period, prog_ticks, prog_tag, prog_v, out_r,
    input  prog_a, out_tag, out_ct, out_v
  );

  modport slave (
    input  prog_gen_idx, prog_period, prog_ticks, prog_tag, prog_v, out_r,
    output prog_a, out_tag, out_ct, out_v
  );
endinterface

// File: rtl/spike_gen_bank.sv
// rtl/spike_gen_bank.sv - bank of 2**Ngens periodic spike generators
//
// Ports:
//   clk             clock
//   reset_n         asynchronous active-low reset
//   time_unit_pulse one-cycle time-unit strobe from the time manager
//   bus             slave side of spike_gen_bank_if (programming writes in,
//                   tag/count events out)
//   unit_overrun    sticky: a time unit was dropped
//   busy            high while initialising, scanning or emitting
module spike_gen_bank #(
  parameter int Ngens   = 8,
  parameter int Nperiod = 16,
  parameter int Ntag    = 11,
  parameter int Nct     = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              time_unit_pulse,
  spike_gen_bank_if.slave   bus,
  output logic              unit_overrun,
  output logic              busy
);
  localparam int NGEN = 1 << Ngens;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_SCAN, ST_EMIT} state_t;

  state_t             state_q;
  logic [Ngens-1:0]   idx_q;
  logic               pending_q;
  logic               prog_a_q;
  logic               out_v_q;
  logic [Ntag-1:0]    out_tag_q;
  logic [Nct-1:0]     out_ct_q;
  logic               overrun_q;
  logic               busy_q;

  // Per-generator state, one entry per generator, no reset so it maps to RAM.
  logic [Nperiod-1:0] period_mem [NGEN];
  logic [Nperiod-1:0] ticks_mem  [NGEN];
  logic [Ntag-1:0]    tag_mem    [NGEN];

  logic [Nperiod-1:0] cur_period;
  logic [Nperiod-1:0] cur_ticks;
  logic [Ntag-1:0]    cur_tag;
  logic               last_idx;
  logic               prog_take;
  logic               fire;
  logic               unit_busy;

  assign cur_period = period_mem[idx_q];
  assign cur_ticks  = ticks_mem[idx_q];
  assign cur_tag    = tag_mem[idx_q];
  assign last_idx   = &idx_q;

  // prog_a_q blocks a second ack while the programmer is still dropping prog_v.
  assign prog_take  = (state_q == ST_IDLE) && bus.prog_v && !prog_a_q;
  assign fire       = (state_q == ST_SCAN) && (cur_period != '0) && (cur_ticks == '0);
  assign unit_busy  = (state_q == ST_SCAN) || (state_q == ST_EMIT);

  // Array write ports: INIT, programming and scanning are state-exclusive,
  // so each array needs only a single write port.
  logic               period_we;
  logic [Ngens-1:0]   period_waddr;
  logic [Nperiod-1:0] period_d;
  logic               ticks_we;
  logic [Ngens-1:0]   ticks_waddr;
  logic [Nperiod-1:0] ticks_d;
  logic               tag_we;
  logic [Ntag-1:0]    tag_d;

  always_comb begin
    period_we    = 1'b0;
    period_waddr = idx_q;
    period_d     = '0;
    ticks_we     = 1'b0;
    ticks_waddr  = idx_q;
    ticks_d      = '0;
    tag_we       = 1'b0;
    tag_d        = bus.prog_tag;
    if (state_q == ST_INIT) begin
      period_we = 1'b1;
    end else if (prog_take) begin
      period_we    = 1'b1;
      period_waddr = bus.prog_gen_idx;
      period_d     = bus.prog_period;
      ticks_we     = 1'b1;
      ticks_waddr  = bus.prog_gen_idx;
      ticks_d      = bus.prog_ticks;
      tag_we       = 1'b1;
    end else if ((state_q == ST_SCAN) && (cur_period != '0)) begin
      ticks_we = 1'b1;
      ticks_d  = (cur_ticks == '0) ? cur_period - Nperiod'(1) : cur_ticks - Nperiod'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (period_we) period_mem[period_waddr] <= period_d;
    if (ticks_we)  ticks_mem[ticks_waddr]   <= ticks_d;
    if (tag_we)    tag_mem[bus.prog_gen_idx] <= tag_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_INIT;
      idx_q     <= '0;
      pending_q <= 1'b0;
      prog_a_q  <= 1'b0;
      out_v_q   <= 1'b0;
      out_tag_q <= '0;
      out_ct_q  <= '0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      prog_a_q <= prog_take;

      // A unit that cannot be buffered is dropped and flagged; pulses during
      // INIT are ignored entirely.
      if (time_unit_pulse && unit_busy) begin
        if (pending_q) overrun_q <= 1'b1;
        else           pending_q <= 1'b1;
      end

      case (state_q)
        ST_INIT: begin
          if (last_idx) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            idx_q   <= '0;
          end else begin
            idx_q <= idx_q + Ngens'(1);
          end
        end

        ST_IDLE: begin
          if (prog_take) begin
            if (time_unit_pulse) begin
              if (pending_q) overrun_q <= 1'b1;
              pending_q <= 1'b1;
            end
          end else if (time_unit_pulse || pending_q) begin
            // A pulse coinciding with a consumed pending unit stays buffered.
            pending_q <= time_unit_pulse && pending_q;
            idx_q     <= '0;
            state_q   <= ST_SCAN;
            busy_q    <= 1'b1;
          end
        end

        ST_SCAN: begin
          if (fire) begin
            out_v_q   <= 1'b1;
            out_tag_q <= cur_tag;
            out_ct_q  <= Nct'(1);
            state_q   <= ST_EMIT;
          end else if (last_idx) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            idx_q <= idx_q + Ngens'(1);
          end
        end

        ST_EMIT: begin
          if (bus.out_r) begin
            out_v_q <= 1'b0;
            if (last_idx) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              idx_q   <= idx_q + Ngens'(1);
              state_q <= ST_SCAN;
            end
          end
        end

        default: begin
          state_q <= ST_INIT;
          idx_q   <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.prog_a   = prog_a_q;
  assign bus.out_v    = out_v_q;
  assign bus.out_tag  = out_tag_q;
  assign bus.out_ct   = out_ct_q;
  assign unit_overrun = overrun_q;
  assign busy         = busy_q;
endmodule

// File: tb/tb_spike_gen_bank.sv
// tb/tb_spike_gen_bank.sv - self-checking bench for spike_gen_bank
module tb_spike_gen_bank;
  localparam int NG = 2, NP = 16, NT = 11, NC = 10, NGEN = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic time_unit_pulse = 1'b0;
  logic unit_overrun, busy;

  spike_gen_bank_if #(.Ngens(NG), .Nperiod(NP), .Ntag(NT), .Nct(NC)) bus ();

  spike_gen_bank #(.Ngens(NG), .Nperiod(NP), .Ntag(NT), .Nct(NC)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .time_unit_pulse (time_unit_pulse),
    .bus             (bus),
    .unit_overrun    (unit_overrun),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Transfers observed on the event channel.
  logic [NT-1:0] got_tag[$];
  logic [NC-1:0] got_ct[$];
  always @(negedge clk) begin
    if (reset_n && bus.out_v && bus.out_r) begin
      got_tag.push_back(bus.out_tag);
      got_ct.push_back(bus.out_ct);
    end
  end

  // Reference model: each generator fires on the n-th unit after it was
  // programmed whenever n >= ticks and (n - ticks) is a multiple of period.
  int mp[NGEN], mk[NGEN], ms[NGEN], mt[NGEN];
  int units_done;
  int exp_tag[$];

  function automatic void model_reset();
    for (int i = 0; i < NGEN; i++) mp[i] = 0;
    units_done = 0;
  endfunction

  function automatic void model_prog(int g, int p, int k, int t);
    mp[g] = p; mk[g] = k; mt[g] = t; ms[g] = units_done;
  endfunction

  function automatic void model_unit();
    for (int i = 0; i < NGEN; i++) begin
      if (mp[i] != 0) begin
        int n;
        n = units_done - ms[i];
        if (n >= mk[i] && ((n - mk[i]) % mp[i]) == 0) exp_tag.push_back(mt[i]);
      end
    end
    units_done++;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    got_tag.delete(); got_ct.delete(); exp_tag.delete();
  endtask

  task automatic cmp_events(input string name);
    chk({name, "_count"}, got_tag.size(), exp_tag.size());
    for (int i = 0; i < exp_tag.size() && i < got_tag.size(); i++) begin
      chk({name, "_tag"}, got_tag[i], exp_tag[i]);
      chk({name, "_ct"}, got_ct[i], 1);
    end
    clear_events();
  endtask

  task automatic program_gen(input int g, input int p, input int k, input int t);
    int  n = 0;
    bit  acked = 0;
    bus.prog_gen_idx = g[NG-1:0];
    bus.prog_period  = p[NP-1:0];
    bus.prog_ticks   = k[NP-1:0];
    bus.prog_tag     = t[NT-1:0];
    bus.prog_v       = 1'b1;
    while (!acked && n < 50) begin
      @(negedge clk);
      if (bus.prog_a) acked = 1;
      step();
      n++;
    end
    bus.prog_v = 1'b0;
    chk("prog_ack", acked, 1);
    model_prog(g, p, k, t);
  endtask

  task automatic run_unit(input bit rand_r);
    int n = 0;
    time_unit_pulse = 1'b1;
    step();
    time_unit_pulse = 1'b0;
    while (n < 300) begin
      @(negedge clk);
      if (!busy) break;
      step();
      if (rand_r) bus.out_r = 1'($urandom_range(0, 1));
      n++;
    end
    chk("unit_done", busy, 0);
    step();
    bus.out_r = 1'b1;
  endtask

  // Counts INIT cycles after reset release, with a pulse injected mid-INIT.
  task automatic check_init(input string name);
    int nb = 0, pa = 0, ib = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!busy) break;
      nb++;
      if (bus.prog_a) pa++;
      step();
      time_unit_pulse = (c == 1);
    end
    time_unit_pulse = 1'b0;
    chk({name, "_busy_cycles"}, nb, NGEN);
    chk({name, "_prog_a"}, pa, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (busy) ib++;
      step();
    end
    chk({name, "_pulse_ignored"}, ib, 0);
  endtask

  typedef struct {
    bit do_prog;
    int g, p, k, tag;
    bit do_unit;
    int exp_n;
    int t0, t1;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int n, early, acks;

    tbl[0]  = '{1, 1, 3, 0, 'h055, 1, 1, 'h055, 0};
    tbl[1]  = '{0, 0, 0, 0, 0,     1, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 0,     1, 0, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 0,     1, 1, 'h055, 0};
    tbl[4]  = '{0, 0, 0, 0, 0,     1, 0, 0, 0};
    tbl[5]  = '{0, 0, 0, 0, 0,     1, 0, 0, 0};
    tbl[6]  = '{0, 0, 0, 0, 0,     1, 1, 'h055, 0};
    tbl[7]  = '{1, 1, 0, 0, 'h055, 0, 0, 0, 0};
    tbl[8]  = '{1, 0, 1, 0, 'h001, 0, 0, 0, 0};
    tbl[9]  = '{1, 2, 2, 1, 'h002, 1, 1, 'h001, 0};
    tbl[10] = '{0, 0, 0, 0, 0,     1, 2, 'h001, 'h002};
    tbl[11] = '{0, 0, 0, 0, 0,     1, 1, 'h001, 0};

    bus.out_r = 1'b1;
    bus.prog_gen_idx = '0; bus.prog_period = '0; bus.prog_ticks = '0; bus.prog_tag = '0;
    bus.prog_v = 1'b1;      // held through INIT: must not be acked there
    model_reset();
    clear_events();

    // Reset values
    step(); step();
    @(negedge clk);
    chk("rst_out_v", bus.out_v, 0);
    chk("rst_out_tag", bus.out_tag, 0);
    chk("rst_out_ct", bus.out_ct, 0);
    chk("rst_prog_a", bus.prog_a, 0);
    chk("rst_overrun", unit_overrun, 0);
    chk("rst_busy", busy, 1);
    step();
    reset_n = 1'b1;
    check_init("init");
    program_gen(0, 0, 0, 0);
    for (int u = 0; u < 3; u++) begin
      run_unit(0);
      model_unit();
      cmp_events("empty_unit");
    end

    // Table-driven programming and firing patterns
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].do_prog) program_gen(tbl[i].g, tbl[i].p, tbl[i].k, tbl[i].tag);
      if (tbl[i].do_unit) begin
        run_unit(0);
        model_unit();
        exp_tag.delete();
        chk("tbl_count", got_tag.size(), tbl[i].exp_n);
        if (tbl[i].exp_n >= 1 && got_tag.size() >= 1) begin
          chk("tbl_tag0", got_tag[0], tbl[i].t0);
          chk("tbl_ct0", got_ct[0], 1);
        end
        if (tbl[i].exp_n >= 2 && got_tag.size() >= 2) chk("tbl_tag1", got_tag[1], tbl[i].t1);
        clear_events();
      end
    end

    // Backpressure: event held, pulses buffered then dropped
    for (int g = 0; g < NGEN; g++) program_gen(g, 0, 0, 0);
    program_gen(1, 1, 0, 'h123);
    program_gen(2, 1, 0, 'h456);
    bus.out_r = 1'b0;
    time_unit_pulse = 1'b1;
    step();
    time_unit_pulse = 1'b0;
    model_unit();
    n = 0;
    while (!bus.out_v && n < 20) begin step(); n++; end
    chk("bp_out_v_rise", bus.out_v, 1);
    for (int c = 0; c < 10; c++) begin
      time_unit_pulse = (c == 2 || c == 5);
      step();
      time_unit_pulse = 1'b0;
      chk("bp_hold_v", bus.out_v, 1);
      chk("bp_hold_tag", bus.out_tag, 'h123);
      if (c == 2) begin
        chk("bp_overrun_after_first", unit_overrun, 0);
        model_unit();
      end
      if (c == 5) chk("bp_overrun_after_second", unit_overrun, 1);
    end
    bus.out_r = 1'b1;
    for (int c = 0; c < 40; c++) step();
    chk("bp_done", busy, 0);
    cmp_events("bp_events");

    // Programming attempted during SCAN
    time_unit_pulse = 1'b1;
    step();
    time_unit_pulse = 1'b0;
    model_unit();
    bus.prog_gen_idx = 2'd1; bus.prog_period = '0; bus.prog_ticks = '0; bus.prog_tag = 11'h123;
    bus.prog_v = 1'b1;
    early = 0; n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (!busy) break;
      if (bus.prog_a) early++;
      step();
      n++;
    end
    chk("scan_prog_a_held", early, 0);
    acks = 0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      if (bus.prog_a) acks++;
      step();
      if (acks > 0) bus.prog_v = 1'b0;
    end
    bus.prog_v = 1'b0;
    chk("scan_prog_a_pulses", acks, 1);
    model_prog(1, 0, 0, 'h123);
    cmp_events("scan_unit_events");
    run_unit(0);
    model_unit();
    cmp_events("after_disable_events");

    // Randomised programming and backpressure against the model
    for (int u = 0; u < 25; u++) begin
      if ($urandom_range(0, 2) == 0) begin
        program_gen($urandom_range(0, NGEN - 1), $urandom_range(0, 4),
                    $urandom_range(0, 5), $urandom_range(0, 2047));
      end
      run_unit(1);
      model_unit();
      cmp_events("rand_events");
    end
    chk("overrun_sticky", unit_overrun, 1);

    // Reset asserted while an event is held
    for (int g = 0; g < NGEN; g++) program_gen(g, 1, 0, 'h200 + g);
    bus.out_r = 1'b0;
    time_unit_pulse = 1'b1;
    step();
    time_unit_pulse = 1'b0;
    n = 0;
    while (!bus.out_v && n < 20) begin step(); n++; end
    chk("rst_mid_out_v_before", bus.out_v, 1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_out_v", bus.out_v, 0);
    chk("rst_mid_out_tag", bus.out_tag, 0);
    chk("rst_mid_busy", busy, 1);
    chk("rst_mid_overrun", unit_overrun, 0);
    model_reset();
    clear_events();
    step(); step();
    reset_n = 1'b1;
    bus.out_r = 1'b1;
    check_init("reinit");
    for (int u = 0; u < 3; u++) begin
      run_unit(0);
      model_unit();
      cmp_events("post_reset_events");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spike_gen_bank.md
Name: spike_gen_bank

Overview:
- Responder end of the spike-generator programming channel: accepts per-generator programming writes and runs a bank of 2**Ngens periodic spike generators.
- On each time unit from the time manager, it scans every generator, decrements or reloads its phase counter, and emits a tag/count event for each generator that fires.
- Events leave on a tag/count valid-ready channel toward the router/merge path.
- The generator state is held in indexed arrays, one entry per generator, so that it maps to RAM.

Parameters:
- Ngens, 8, index width; the bank holds 2**Ngens generators.
- Nperiod, 16, width of the period and phase counters, in time units.
- Ntag, 11, width of the output tag.
- Nct, 10, width of the output count.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- time_unit_pulse  in  1  one-cycle strobe from the time manager marking a time-unit boundary.
- prog_gen_idx  in  Ngens  generator being programmed.
- prog_period  in  Nperiod  firing period in time units; 0 disables the generator.
- prog_ticks  in  Nperiod  initial phase, in time units until the first fire.
- prog_tag  in  Ntag  tag emitted when this generator fires.
- prog_v  in  1  program write valid; held until acknowledged.
- prog_a  out  1  one-cycle acknowledge; the write is committed in that cycle.
- out_tag  out  Ntag  emitted tag.
- out_ct  out  Nct  emitted count; always 1.
- out_v  out  1  output valid.
- out_r  in  1  output ready.
- unit_overrun  out  1  sticky flag: a time unit was dropped.
- busy  out  1  high in INIT, SCAN and EMIT.

Behaviour:
- Asynchronous reset values:
  - out_v=0, out_tag=0, out_ct=0.
  - prog_a=0, unit_overrun=0.
  - pending=0, state=INIT, scan index=0.
- States:
  - INIT: writes period[idx]=0, one index per cycle, for idx 0..2**Ngens-1, then goes to IDLE. Takes exactly 2**Ngens cycles. time_unit_pulse during INIT is ignored and does not set pending.
  - IDLE:
    - prog_v=1: write period, ticks and tag at prog_gen_idx and assert prog_a for one cycle. prog_a is never high on two consecutive cycles; the programmer must drop prog_v after the ack.
    - Otherwise, time_unit_pulse=1 or pending=1: clear pending, set idx=0, go to SCAN.
    - A program write takes priority; a time_unit_pulse in that same cycle sets pending.
  - SCAN: examines generator idx in one cycle.
    - period==0: no change, no emission.
    - ticks==0: ticks <= period-1, load out_tag=tag[idx], out_ct=1, out_v=1, go to EMIT.
    - Otherwise: ticks <= ticks-1.
    - If no emission: at the last idx go to IDLE, else idx+1.
  - EMIT: hold out_v, out_tag and out_ct stable until out_v&&out_r.
    - In the transfer cycle, out_v drops next cycle.
    - Resume SCAN at idx+1, or go to IDLE if idx was the last.
    - No bubble beyond one cycle per emission.
- Latency:
  - Pulse in IDLE at cycle t: generator i is examined at t+1+i plus accumulated EMIT stall cycles.
  - A firing generator's out_v rises at examine cycle+1.
- Time-unit handling outside IDLE:
  - time_unit_pulse in SCAN or EMIT sets pending, which is one deep.
  - A pulse arriving while pending=1 and not IDLE sets unit_overrun; the unit is dropped.
  - unit_overrun stays high until reset.
- Programming outside IDLE: prog_v in INIT, SCAN or EMIT is not acked; prog_a stays 0 until IDLE. Programming never races a scan.
- Emission order within a unit is ascending generator index.
- Phase semantics: programming ticks=k with period=p fires at the (k+1)th subsequent time unit, then every p units. prog_ticks >= prog_period is legal and simply delays the first fire.
- Reset asserted mid-operation: all outputs return to reset values immediately and INIT reruns. Any in-flight output event is lost.

Test Plan:
- Reset with Ngens=2 -> busy=1 for exactly 4 cycles, prog_a=0 throughout; 3 subsequent pulses produce no out_v.
- Program gen1 period=3 ticks=0 tag=0x055, then 7 pulses (units 0-6) -> events tag=0x055 ct=1 on units 0, 3, 6 only.
- gen0 period=1 tag=0x001; gen2 period=2 ticks=1 tag=0x002 -> unit0: 0x001 only; unit1: 0x001 then 0x002; unit2: 0x001 only.
- Backpressure test:
  - Stimulus: hold out_r=0 for 10 cycles during EMIT, with pulses at cycles 2 and 5.
  - Response: out_tag stays stable, the scan index does not advance, pending=1 after the first pulse, unit_overrun=1 after the second.
  - After out_r=1: the held event transfers, then a second scan runs.
- prog_v raised during SCAN -> prog_a=0 until the cycle after SCAN ends, then exactly one 1-cycle pulse. A write of period=0 to a firing generator stops its events from the next unit.
- Reset_n pulsed low while out_v=1 in EMIT -> out_v=0 within the reset; INIT reruns; previously programmed generators emit nothing afterward.
